// File: rtl/uart_pkg.sv
// Shared types and widths for the UART boot loader.
package uart_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned WordW = 32;

  // Byte receiver states
  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  // Loader phases
  typedef enum logic [1:0] {
    PhHdr,
    PhLoad,
    PhDone
  } phase_e;

endpackage

// File: rtl/uart_loader_if.sv
// Memory write port driven by the loader: word, byte address, write pulse, status.
interface uart_loader_if;

  logic [uart_pkg::WordW-1:0] uart_data;
  logic [uart_pkg::WordW-1:0] uart_addr;
  logic                       uart_wen;
  logic                       uart_done;
  logic                       frame_err;

  modport master (
    output uart_data,
    output uart_addr,
    output uart_wen,
    output uart_done,
    output frame_err
  );

  modport slave (
    input uart_data,
    input uart_addr,
    input uart_wen,
    input uart_done,
    input frame_err
  );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with a 2-FF input synchronizer and sticky frame error.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [ByteW-1:0] byte_out,
  output logic             byte_valid,
  output logic             frame_err
);

  localparam int unsigned Div     = CLK_FREQ / BAUD;
  localparam int unsigned HalfDiv = Div / 2;
  localparam int unsigned CntW    = $clog2(Div);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [2:0]       bit_q;
  logic [ByteW-1:0] shift_q;
  logic             wait_hi_q;

  // Synchronizer resets to idle-high so nothing is acted on until it refills
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // Receiver FSM: mid-bit sampling, registered byte/valid/error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RxIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wait_hi_q  <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          cnt_q <= '0;
          bit_q <= '0;
          // After a bad stop bit, ignore the line until it returns high
          if (wait_hi_q) begin
            if (rx_s) wait_hi_q <= 1'b0;
          end else if (!rx_s) begin
            state_q <= RxStart;
          end
        end
        RxStart: begin
          if (cnt_q == CntW'(HalfDiv - 1)) begin
            cnt_q   <= '0;
            state_q <= rx_s ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == CntW'(Div - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[ByteW-1:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == CntW'(Div - 1)) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (rx_s) begin
              byte_out   <= shift_q;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              wait_hi_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: header word count N, then N little-endian words written to memory.
module uart_loader
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h1c09_0000
) (
  input logic           clk,
  input logic           rst,
  input logic           rx,
  uart_loader_if.master mem
);

  logic [ByteW-1:0] rx_byte;
  logic             rx_valid;
  logic             rx_ferr;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_out   (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  phase_e           phase_q;
  logic [1:0]       pos_q;
  logic [23:0]      word_q;   // bytes received so far of the current word
  logic [WordW-1:0] n_q;
  logic [WordW-1:0] k_q;
  logic [WordW-1:0] data_q;
  logic [WordW-1:0] addr_q;
  logic             wen_q;
  logic             done_q;
  logic [WordW-1:0] asm_word;

  // Newest byte lands on top so the first byte ends up in bits 7:0
  assign asm_word = {rx_byte, word_q};

  // Phase FSM and word assembler with registered memory-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PhHdr;
      pos_q   <= '0;
      word_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      data_q  <= '0;
      addr_q  <= BASE_ADDR;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      unique case (phase_q)
        PhHdr: begin
          if (rx_valid) begin
            word_q <= asm_word[WordW-1:ByteW];
            pos_q  <= pos_q + 2'd1;
            if (pos_q == 2'd3) begin
              n_q <= asm_word;
              k_q <= '0;
              if (asm_word == '0) begin
                phase_q <= PhDone;
                done_q  <= 1'b1;
              end else begin
                phase_q <= PhLoad;
              end
            end
          end
        end
        PhLoad: begin
          if (rx_valid) begin
            word_q <= asm_word[WordW-1:ByteW];
            pos_q  <= pos_q + 2'd1;
            if (pos_q == 2'd3) begin
              data_q <= asm_word;
              addr_q <= BASE_ADDR + (k_q << 2);
              wen_q  <= 1'b1;
              k_q    <= k_q + 1'b1;
              if (k_q == n_q - 1'b1) phase_q <= PhDone;
            end
          end
        end
        PhDone: done_q <= 1'b1;
        default: phase_q <= PhHdr;
      endcase
    end
  end

  assign mem.uart_data = data_q;
  assign mem.uart_addr = addr_q;
  assign mem.uart_wen  = wen_q;
  assign mem.uart_done = done_q;
  assign mem.frame_err = rx_ferr;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader at DIV = 16 with a byte-list reference model.
module tb_uart_loader;

  localparam logic [31:0] Base = 32'h1c09_0000;
  localparam int          Div  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_loader_if mem_if ();

  uart_loader #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .BASE_ADDR (Base)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .mem (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state: list of good bytes since reset
  logic [7:0]  good_q[$];
  logic [31:0] n_m;
  int unsigned k_m;
  bit          done_m;
  bit          fe_m;
  logic [31:0] last_data_m;
  logic [31:0] last_addr_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    good_q.delete();
    n_m = '0;
    k_m = 0;
    done_m = 1'b0;
    fe_m = 1'b0;
    last_data_m = '0;
    last_addr_m = Base;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    int   sz;
    exp_t e;
    if (!good) begin
      fe_m = 1'b1;
      return;
    end
    if (done_m) return;
    good_q.push_back(b);
    sz = good_q.size();
    if (sz == 4) begin
      n_m = {good_q[3], good_q[2], good_q[1], good_q[0]};
      if (n_m == 0) done_m = 1'b1;
    end else if (sz > 4 && (sz % 4) == 0) begin
      e.data = {good_q[sz-1], good_q[sz-2], good_q[sz-3], good_q[sz-4]};
      e.addr = Base + 32'(4 * k_m);
      k_m++;
      e.last = (k_m == n_m);
      if (e.last) done_m = 1'b1;
      last_data_m = e.data;
      last_addr_m = e.addr;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (Div) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    model_byte(b, good);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good);
    rx = 1'b1;
    repeat (good ? 4 : 20) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_data", mem_if.uart_data, 32'h0);
    chk("rst_addr", mem_if.uart_addr, Base);
    chk("rst_wen", {31'b0, mem_if.uart_wen}, 32'h0);
    chk("rst_done", {31'b0, mem_if.uart_done}, 32'h0);
    chk("rst_ferr", {31'b0, mem_if.frame_err}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    repeat (20) @(negedge clk);
    chk({tag, "_done"}, {31'b0, mem_if.uart_done}, {31'b0, done_m});
    chk({tag, "_ferr"}, {31'b0, mem_if.frame_err}, {31'b0, fe_m});
    chk({tag, "_data"}, mem_if.uart_data, last_data_m);
    chk({tag, "_addr"}, mem_if.uart_addr, last_addr_m);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: pops the scoreboard on every write pulse; done must follow the last word
  bit chk_done_next = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk_done_next = 1'b0;
    end else begin
      if (chk_done_next) begin
        chk("done_after_last", {31'b0, mem_if.uart_done}, 32'h1);
        chk_done_next = 1'b0;
      end
      if (mem_if.uart_wen) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wen: got addr %h data %h expected no write",
                   mem_if.uart_addr, mem_if.uart_data);
        end else begin
          e = exp_q.pop_front();
          chk("wen_addr", mem_if.uart_addr, e.addr);
          chk("wen_data", mem_if.uart_data, e.data);
          chk("done_at_wen", {31'b0, mem_if.uart_done}, 32'h0);
          if (e.last) chk_done_next = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    model_reset();

    // Two-word load
    do_reset();
    send_word(32'd2);
    send_word(32'h1234_5678);
    send_word(32'hdead_beef);
    check_idle("two_words");

    // Empty image, then traffic after done must be ignored
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    chk("zero_hdr_not_done", {31'b0, mem_if.uart_done}, 32'h0);
    send_byte(8'h00, 1'b1);
    check_idle("zero_hdr");
    send_word(32'h0102_0304);
    check_idle("after_done");

    // Short glitch takes no byte; bad stop bit mid-word is skipped
    do_reset();
    glitch(4);
    chk("glitch_ferr", {31'b0, mem_if.frame_err}, 32'h0);
    send_word(32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'hff, 1'b0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check_idle("frame_err");

    // Reset mid-load and mid-byte, then a fresh load
    do_reset();
    send_word(32'd1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    do_reset();
    send_word(32'd1);
    send_word(32'hddcc_bbaa);
    check_idle("after_rst");

    // Randomized loads with bad frames, glitches and trailing bytes
    for (int it = 0; it < 3; it++) begin
      do_reset();
      n = $urandom_range(1, 3);
      send_word(n);
      for (int w = 0; w < int'(n); w++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, 5) == 0) send_byte(8'($urandom), 1'b0);
          if ($urandom_range(0, 7) == 0) glitch($urandom_range(1, 6));
          send_byte(8'($urandom), 1'b1);
        end
      end
      send_byte(8'($urandom), 1'b1);
      send_byte(8'($urandom), 1'b1);
      check_idle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; DIV = CLK_FREQ/BAUD (integer, SHALL be >= 4).
REQ-003 Parameter BASE_ADDR, default 32'h1c09_0000, byte address of first loaded word.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 uart_data  output  32  assembled word to write into memory.
REQ-008 uart_addr  output  32  byte address of uart_data.
REQ-009 uart_wen  output  1  one-cycle pulse; uart_data/uart_addr valid and new this cycle.
REQ-010 uart_done  output  1  high once the load is complete; releases CPU from reset.
REQ-011 frame_err  output  1  sticky; set on a bad stop bit.

Function
REQ-012 rx SHALL pass through a 2-FF synchronizer before any use.
REQ-013 Byte receiver states: IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on synchronized rx = 0; START waits DIV/2 cycles, re-samples: 0 -> DATA, 1 -> IDLE (glitch, no byte).
REQ-015 DATA samples rx every DIV cycles, 8 samples, shifted in LSB first; then -> STOP.
REQ-016 STOP samples after DIV cycles: 1 -> byte valid one cycle, -> IDLE; 0 -> frame_err set, byte discarded, -> IDLE after rx returns high.
REQ-017 Loader phases: HDR, LOAD, DONE.
REQ-018 HDR: first 4 valid bytes, little-endian, form word count N (32-bit).
REQ-019 HDR exit: N = 0 -> DONE directly; else -> LOAD with index k = 0.
REQ-020 LOAD: every 4 valid bytes, little-endian (first byte -> bits 7:0), form one word.
REQ-021 Word emission: uart_data <= word; uart_addr <= BASE_ADDR + 4*k; both change in the same cycle; uart_wen = 1 for exactly that cycle.
REQ-022 uart_data and uart_addr SHALL hold their values between emissions (memory port writes continuously while uart_done = 0).
REQ-023 Latency: uart_wen asserts the cycle after the 4th byte's valid pulse.
REQ-024 After word k = N-1 is emitted, next cycle -> DONE; uart_done = 1 from then until reset.
REQ-025 DONE: bytes still received (frame_err still tracked), but no emission; uart_data/uart_addr frozen.
REQ-026 uart_addr arithmetic SHALL be 32-bit modulo 2^32; wrap-around is not flagged.
REQ-027 A frame error SHALL NOT reset the byte-in-word position; the next good byte continues the word.

Reset
REQ-028 On rst: receiver IDLE, phase HDR, byte position 0, k = 0, N = 0.
REQ-029 Reset values: uart_data = 0, uart_addr = BASE_ADDR, uart_wen = 0, uart_done = 0, frame_err = 0.
REQ-030 rst mid-byte or mid-load SHALL abandon all partial data; loading restarts from HDR.
REQ-031 rst release is asynchronous; logic SHALL not act on rx before the synchronizer refills (2 cycles).

Structure
REQ-032 Shared package uart_pkg: rx state enum, loader phase enum, byte width 8, word width 32.
REQ-033 One sub-module uart_rx_byte (REQ-012..016): ports clk, rst, rx, byte_out[7:0], byte_valid, frame_err.
REQ-034 uart_loader instantiates uart_rx_byte and adds the word assembler and phase FSM.

Verification (CLK_FREQ=16, BAUD=1, DIV=16)
REQ-035 Header 02 00 00 00, bytes 78 56 34 12 EF BE AD DE -> wen at 1c090000 = 12345678, then 1c090004 = DEADBEEF; uart_done = 1 next cycle.
REQ-036 Header 00 00 00 00 -> no uart_wen; uart_done = 1 one cycle after 4th header byte valid.
REQ-037 rx low pulse of 4 cycles in IDLE -> no byte, no state change, frame_err = 0.
REQ-038 Byte with stop bit 0 during LOAD -> frame_err = 1 (sticky), word completes on next 4 good bytes.
REQ-039 rst asserted after 2 bytes of word 0 -> outputs to reset values; fresh header 01 00 00 00 + AA BB CC DD -> 1c090000 = DDCCBBAA, done.
REQ-040 Bytes sent after uart_done -> uart_data, uart_addr, uart_done unchanged, uart_wen stays 0.
